reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side sequencer for the 4-entry x 8-bit register file. It is the block that drives the file's write enable, write address and write data.
- Merges two writers into the single write port:
  - ALU results, single-cycle, never stalled.
  - Memory load results, which may arrive late.
- Memory writes that collide with an ALU write are parked in a small FIFO.
- Reports read-after-write hazards to decode for still-pending writes.

Parameters:
- ADDR_W, 2: register address width; must match the register file.
- DATA_W, 8: register data width.
- DEPTH, 2: parking FIFO entries; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_wen  in  1  ALU write request; always accepted
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result valid
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load accepted this cycle when mem_valid && mem_ready
- rd_addr1  in  ADDR_W  decode read address A
- rd_addr2  in  ADDR_W  decode read address B
- hazard  out  1  a pending write targets rd_addr1 or rd_addr2
- q_count  out  $clog2(DEPTH+1)  live-plus-dead FIFO occupancy
- rf_wen  out  1  register file write enable (registered)
- rf_w_addr  out  ADDR_W  register file write address (registered)
- rf_data  out  DATA_W  register file write data (registered)

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: rf_wen=0, rf_w_addr=0, rf_data=0, FIFO empty, q_count=0. After reset deasserts, mem_ready=1 and hazard=0.
- Reset mid-operation: all queued and in-flight writes are discarded. No rf_wen pulse occurs in the cycle after reset.
- Issue selection, once per cycle, in priority order:
  1. alu_wen=1: issue the ALU write.
  2. else FIFO non-empty: pop the head. A live head is issued; a dead head is popped with rf_wen=0.
  3. else accepted load with FIFO empty: issue the load directly. This is the bypass path; there is no push.
  4. else rf_wen=0 next cycle.
- Latency: an issued write appears on rf_* at the next posedge. The register file commits it on the posedge after that.
- Push: an accepted load that is not issued directly is pushed at the FIFO tail.
- mem_ready = (q_count < DEPTH). It depends on the registered count only. A pop in the same cycle does not raise mem_ready that cycle.
- Simultaneous pop and push are allowed; q_count is unchanged.
- Ordering rule: alu_wen with alu_addr=R marks every live FIFO entry with address R dead in the same cycle. An ALU write is always newer than any parked load.
- Same-cycle collision: an accepted load with mem_addr equal to alu_addr (alu_wen=1) is accepted and dropped. It is neither pushed nor issued; the ALU write wins.
- hazard=1 when rd_addr1 or rd_addr2 matches either of:
  - a live FIFO entry, or
  - rf_w_addr while rf_wen=1 (write not yet committed).
- hazard is combinational; there are no other hazard sources.
- FIFO pointers wrap modulo DEPTH. Full means q_count==DEPTH; empty means q_count==0.
- Dead entries count toward q_count until popped.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - Adds ports fwd_hit1/fwd_hit2 (out, 1) and fwd_data1/fwd_data2 (out, DATA_W).
  - fwd_hitN=1 when rd_addrN matches a pending write.
  - fwd_dataN is the youngest match: newest live FIFO entry first, then the rf_* register.
  - hazard is forced to 0; decode uses the forwarded data instead of stalling.
- Undefined: these ports are absent and hazard behaves as described above.

Test Plan:
- Reset, then alu_wen=1, alu_addr=2, alu_data=8'h5A -> next cycle rf_wen=1, rf_w_addr=2, rf_data=8'h5A. Following cycle: rf_wen=0, hazard=0 for rd_addr1=2.
- mem_valid=1 alone, mem_addr=1, mem_data=8'h33, FIFO empty -> bypass, next cycle rf_w_addr=1, rf_data=8'h33, q_count stays 0.
- 3 cycles of alu_wen=1 with mem_valid=1 (addr 0, 8'h11 then addr 3, 8'h22), DEPTH=2:
  - Two loads are pushed; q_count=2 and mem_ready=0.
  - After alu_wen drops: writes 8'h11 then 8'h22 issue on consecutive cycles and q_count returns to 0.
- Load to reg 1 parked, then alu_wen to reg 1 with 8'h77:
  - rf shows 8'h77.
  - The parked entry is popped dead with rf_wen=0.
  - Final commit is 8'h77; hazard on rd_addr1=1 clears once the ALU write commits.
- alu_wen=1 and mem_valid=1, both addr 3 -> only the ALU write issues, q_count=0.
- Reset asserted with q_count=2 -> next cycle q_count=0, rf_wen=0, mem_ready=1. With WB_FWD_EN: a parked load to reg 2 with 8'h9C gives fwd_hit1=1, fwd_data1=8'h9C for rd_addr1=2, and hazard=0.

Source files
------------

// File: rtl/reg_writeback.sv
// Write-port sequencer: ALU writes win, late loads bypass or park in a FIFO; 1-cycle issue to rf_*.
// Backpressure via mem_ready (registered count < DEPTH). WB_FWD_EN adds forwarding outputs.
module reg_writeback #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_wen,
    input  logic [ADDR_W-1:0]            alu_addr,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         mem_ready,
    input  logic [ADDR_W-1:0]            rd_addr1,
    input  logic [ADDR_W-1:0]            rd_addr2,
    output logic                         hazard,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
`ifdef WB_FWD_EN
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
`endif
    output logic                         rf_wen,
    output logic [ADDR_W-1:0]            rf_w_addr,
    output logic [DATA_W-1:0]            rf_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [DEPTH-1:0]  ent_live_q, ent_live_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_wen_q, rf_wen_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic mem_acc, fifo_empty, collide, pop, bypass, push;
    logic hit1, hit2;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign mem_ready  = (count_q < FULL_CNT);
    assign mem_acc    = mem_valid && mem_ready;
    assign fifo_empty = (count_q == '0);
    assign collide    = mem_acc && alu_wen && (mem_addr == alu_addr);
    assign pop        = !alu_wen && !fifo_empty;
    assign bypass     = !alu_wen && fifo_empty && mem_acc;
    assign push       = mem_acc && !collide && !bypass;

    always_comb begin
        rf_wen_d  = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (alu_wen) begin
            rf_wen_d  = 1'b1;
            rf_addr_d = alu_addr;
            rf_data_d = alu_data;
        end else if (pop) begin
            rf_wen_d = ent_live_q[rd_ptr_q];
            if (ent_live_q[rd_ptr_q]) begin
                rf_addr_d = ent_addr_q[rd_ptr_q];
                rf_data_d = ent_data_q[rd_ptr_q];
            end
        end else if (bypass) begin
            rf_wen_d  = 1'b1;
            rf_addr_d = mem_addr;
            rf_data_d = mem_data;
        end
    end

    // An ALU write is newer than every parked load, so it kills matching entries.
    always_comb begin
        ent_live_d = ent_live_q;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_wen && (ent_addr_q[i] == alu_addr)) begin
                ent_live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            ent_live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            ent_live_d[wr_ptr_q] = 1'b1;
            ent_addr_d[wr_ptr_q] = mem_addr;
            ent_data_d[wr_ptr_q] = mem_data;
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
            ent_live_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_wen_q   <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
            ent_live_q <= ent_live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_wen_q   <= rf_wen_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    always_comb begin
        hit1 = rf_wen_q && (rf_addr_q == rd_addr1);
        hit2 = rf_wen_q && (rf_addr_q == rd_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live_q[i] && (ent_addr_q[i] == rd_addr1)) hit1 = 1'b1;
            if (ent_live_q[i] && (ent_addr_q[i] == rd_addr2)) hit2 = 1'b1;
        end
    end

`ifdef WB_FWD_EN
    // Youngest match wins: FIFO entries by age from head, rf_* register as fallback.
    always_comb begin
        int best1, best2, age;
        best1     = -1;
        best2     = -1;
        age       = 0;
        fwd_data1 = rf_data_q;
        fwd_data2 = rf_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            age = i - int'(rd_ptr_q);
            if (age < 0) age = age + DEPTH;
            if (ent_live_q[i] && (ent_addr_q[i] == rd_addr1) && (age > best1)) begin
                fwd_data1 = ent_data_q[i];
                best1     = age;
            end
            if (ent_live_q[i] && (ent_addr_q[i] == rd_addr2) && (age > best2)) begin
                fwd_data2 = ent_data_q[i];
                best2     = age;
            end
        end
    end
    assign fwd_hit1 = hit1;
    assign fwd_hit2 = hit2;
    assign hazard   = 1'b0;
`else
    assign hazard   = hit1 || hit2;
`endif

    assign q_count   = count_q;
    assign rf_wen    = rf_wen_q;
    assign rf_w_addr = rf_addr_q;
    assign rf_data   = rf_data_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback at default parameters (DEPTH=2).
module tb_reg_writeback;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_wen;
    logic [1:0] alu_addr;
    logic [7:0] alu_data;
    logic       mem_valid;
    logic [1:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic [1:0] rd_addr1;
    logic [1:0] rd_addr2;
    logic       hazard;
    logic [1:0] q_count;
    logic       rf_wen;
    logic [1:0] rf_w_addr;
    logic [7:0] rf_data;
`ifdef WB_FWD_EN
    logic       fwd_hit1, fwd_hit2;
    logic [7:0] fwd_data1, fwd_data2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .alu_wen   (alu_wen),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .hazard    (hazard),
        .q_count   (q_count),
`ifdef WB_FWD_EN
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
`endif
        .rf_wen    (rf_wen),
        .rf_w_addr (rf_w_addr),
        .rf_data   (rf_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_wen   = 1'b0;
        alu_addr  = 2'd0;
        alu_data  = 8'h00;
        mem_valid = 1'b0;
        mem_addr  = 2'd0;
        mem_data  = 8'h00;
    endtask

    task automatic alu(input logic [1:0] a, input logic [7:0] d);
        alu_wen  = 1'b1;
        alu_addr = a;
        alu_data = d;
    endtask

    task automatic mem(input logic [1:0] a, input logic [7:0] d);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_data  = d;
    endtask

    initial begin
        idle();
        reset    = 1'b1;
        rd_addr1 = 2'd0;
        rd_addr2 = 2'd0;
        tick();
        tick();
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_rf_addr", 32'(rf_w_addr), 32'd0);
        chk("rst_rf_data", 32'(rf_data), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_hazard", 32'(hazard), 32'd0);

        // ALU write
        alu(2'd2, 8'h5A);
        tick();
        idle();
        rd_addr1 = 2'd2;
        #1;
        chk("alu_rf_wen", 32'(rf_wen), 32'd1);
        chk("alu_rf_addr", 32'(rf_w_addr), 32'd2);
        chk("alu_rf_data", 32'(rf_data), 32'h5A);
`ifndef WB_FWD_EN
        chk("alu_hazard_pend", 32'(hazard), 32'd1);
`endif
        tick();
        chk("alu_rf_wen_drop", 32'(rf_wen), 32'd0);
        chk("alu_hazard_clr", 32'(hazard), 32'd0);

        // Load bypass
        mem(2'd1, 8'h33);
        tick();
        idle();
        chk("byp_rf_wen", 32'(rf_wen), 32'd1);
        chk("byp_rf_addr", 32'(rf_w_addr), 32'd1);
        chk("byp_rf_data", 32'(rf_data), 32'h33);
        chk("byp_q_count", 32'(q_count), 32'd0);
        tick();

        // Park two loads behind ALU traffic, third load refused while full
        rd_addr1 = 2'd0;
        alu(2'd2, 8'h01);
        mem(2'd0, 8'h11);
        tick();
        chk("park1_q_count", 32'(q_count), 32'd1);
        chk("park1_rf_data", 32'(rf_data), 32'h01);
        chk("park1_mem_ready", 32'(mem_ready), 32'd1);
        alu(2'd2, 8'h02);
        mem(2'd3, 8'h22);
        tick();
        chk("park2_q_count", 32'(q_count), 32'd2);
        chk("park2_mem_ready", 32'(mem_ready), 32'd0);
        alu(2'd2, 8'h03);
        mem(2'd1, 8'h44);
        tick();
        chk("full_q_count", 32'(q_count), 32'd2);
        chk("full_rf_data", 32'(rf_data), 32'h03);
`ifndef WB_FWD_EN
        chk("full_hazard_live", 32'(hazard), 32'd1);
`endif
        idle();
        tick();
        chk("drain1_rf_wen", 32'(rf_wen), 32'd1);
        chk("drain1_rf_addr", 32'(rf_w_addr), 32'd0);
        chk("drain1_rf_data", 32'(rf_data), 32'h11);
        chk("drain1_q_count", 32'(q_count), 32'd1);
        tick();
        chk("drain2_rf_wen", 32'(rf_wen), 32'd1);
        chk("drain2_rf_addr", 32'(rf_w_addr), 32'd3);
        chk("drain2_rf_data", 32'(rf_data), 32'h22);
        chk("drain2_q_count", 32'(q_count), 32'd0);
        tick();
        chk("drain_idle_rf_wen", 32'(rf_wen), 32'd0);

        // Parked load to reg 1 killed by a newer ALU write
        alu(2'd0, 8'hAA);
        mem(2'd1, 8'h55);
        tick();
        chk("kill_park_q_count", 32'(q_count), 32'd1);
        idle();
        alu(2'd1, 8'h77);
        rd_addr1 = 2'd1;
        tick();
        idle();
        #1;
        chk("kill_rf_wen", 32'(rf_wen), 32'd1);
        chk("kill_rf_addr", 32'(rf_w_addr), 32'd1);
        chk("kill_rf_data", 32'(rf_data), 32'h77);
        chk("kill_q_count", 32'(q_count), 32'd1);
`ifndef WB_FWD_EN
        chk("kill_hazard_rf", 32'(hazard), 32'd1);
`endif
        tick();
        chk("dead_pop_rf_wen", 32'(rf_wen), 32'd0);
        chk("dead_pop_q_count", 32'(q_count), 32'd0);
        chk("dead_pop_hazard", 32'(hazard), 32'd0);
        tick();
        chk("dead_after_rf_wen", 32'(rf_wen), 32'd0);

        // Same-cycle collision: load dropped
        alu(2'd3, 8'h66);
        mem(2'd3, 8'h99);
        tick();
        idle();
        chk("coll_rf_addr", 32'(rf_w_addr), 32'd3);
        chk("coll_rf_data", 32'(rf_data), 32'h66);
        chk("coll_q_count", 32'(q_count), 32'd0);
        tick();
        chk("coll_after_rf_wen", 32'(rf_wen), 32'd0);

        // Fill FIFO, then reset mid-operation
        rd_addr1 = 2'd2;
        alu(2'd0, 8'h01);
        mem(2'd2, 8'h9C);
        tick();
        alu(2'd0, 8'h02);
        mem(2'd3, 8'h10);
        tick();
        idle();
        #1;
        chk("prerst_q_count", 32'(q_count), 32'd2);
`ifdef WB_FWD_EN
        chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
        chk("fwd_data1", 32'(fwd_data1), 32'h9C);
        chk("fwd_hazard", 32'(hazard), 32'd0);
`else
        chk("prerst_hazard", 32'(hazard), 32'd1);
`endif
        reset = 1'b1;
        tick();
        chk("midrst_q_count", 32'(q_count), 32'd0);
        chk("midrst_rf_wen", 32'(rf_wen), 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_mem_ready", 32'(mem_ready), 32'd1);
        chk("midrst_hazard", 32'(hazard), 32'd0);
        tick();
        chk("postrst_rf_wen", 32'(rf_wen), 32'd0);
        chk("postrst_q_count", 32'(q_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
